apb_cmd_master: RTL and testbench

- Synthesizable APB initiator. It turns single-transfer commands from an on-chip controller (CPU-side glue or sequencer) into APB3 transactions toward CoreUARTapb-class slaves.
- It returns each read data / error result through a response handshake.
- It replaces the simulation-only APB master for hardware bring-up and drives up to NUM_SLAVES one-hot PSEL lines.

---
 rtl/apb_cmd_master_pkg.sv | 16 +
 rtl/apb_cmd_master.sv | 199 +++++++++++++++++++
 tb/tb_apb_cmd_master.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_cmd_master_pkg.sv
// Shared types and default widths for the APB command master.
// FSM encoding, default bus widths and the timeout counter width.
package apb_cmd_master_pkg;

   localparam int APB_AW_DEF = 5;
   localparam int APB_DW_DEF = 8;
   localparam int TMO_CW     = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_e;

endpackage

// File: rtl/apb_cmd_master.sv
// Single-transfer command to APB3 initiator with a registered response handshake.
// Optional ACCESS-phase abort is built only when APB_CMD_MASTER_TIMEOUT_EN is defined.
module apb_cmd_master
   import apb_cmd_master_pkg::*;
#(
   parameter int APB_AW         = APB_AW_DEF,
   parameter int APB_DW         = APB_DW_DEF,
   parameter int NUM_SLAVES     = 2,
   parameter int SEL_W          = 1,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  PCLK,
   input  logic                  PRESETN,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [SEL_W-1:0]      cmd_sel,
   input  logic [APB_AW-1:0]     cmd_addr,
   input  logic [APB_DW-1:0]     cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [APB_DW-1:0]     rsp_rdata,
   output logic                  rsp_err,
   output logic                  rsp_timeout,
   output logic [APB_AW-1:0]     PADDR,
   output logic [NUM_SLAVES-1:0] PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [APB_DW-1:0]     PWDATA,
   input  logic [APB_DW-1:0]     PRDATA,
   input  logic                  PREADY,
   input  logic                  PSLVERR
);

   if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || (1 << SEL_W) < NUM_SLAVES ||
       TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (1 << TMO_CW) - 1) begin : g_bad_cfg
      $error("apb_cmd_master: illegal parameter combination");
   end

   state_e                state_q, state_d;
   logic                  cmd_ready_q, cmd_ready_d;
   logic [NUM_SLAVES-1:0] psel_q, psel_d;
   logic                  penable_q, penable_d;
   logic [APB_AW-1:0]     paddr_q, paddr_d;
   logic                  pwrite_q, pwrite_d;
   logic [APB_DW-1:0]     pwdata_q, pwdata_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [APB_DW-1:0]     rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_err_q, rsp_err_d;
   logic [NUM_SLAVES-1:0] sel_onehot;
   logic                  bad_sel;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
   logic [TMO_CW-1:0]     tmo_cnt_q, tmo_cnt_d;
   logic                  rsp_timeout_q, rsp_timeout_d;
`endif

   assign bad_sel = int'(cmd_sel) >= NUM_SLAVES;

   always_comb begin
      sel_onehot = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (cmd_sel == SEL_W'(i)) sel_onehot[i] = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      cmd_ready_d = 1'b0;
      psel_d      = psel_q;
      penable_d   = penable_q;
      paddr_d     = paddr_q;
      pwrite_d    = pwrite_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
      tmo_cnt_d     = tmo_cnt_q;
      rsp_timeout_d = rsp_timeout_q;
`endif
      case (state_q)
         IDLE: begin
            cmd_ready_d = 1'b1;
            if (cmd_valid && cmd_ready_q) begin
               cmd_ready_d = 1'b0;
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b0;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
               rsp_timeout_d = 1'b0;
`endif
               // An unmapped select is answered with an error and never reaches the bus.
               if (bad_sel) begin
                  rsp_err_d   = 1'b1;
                  rsp_valid_d = 1'b1;
                  state_d     = RESP;
               end else begin
                  psel_d    = sel_onehot;
                  penable_d = 1'b0;
                  paddr_d   = cmd_addr;
                  pwrite_d  = cmd_write;
                  pwdata_d  = cmd_write ? cmd_wdata : '0;
                  state_d   = SETUP;
               end
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            state_d   = ACCESS;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
         end
         ACCESS: begin
            if (PREADY) begin
               rsp_rdata_d = pwrite_q ? '0 : PRDATA;
               rsp_err_d   = PSLVERR;
               psel_d      = '0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end
`ifdef APB_CMD_MASTER_TIMEOUT_EN
            else if (tmo_cnt_q == TMO_CW'(TIMEOUT_CYCLES - 1)) begin
               rsp_rdata_d   = '0;
               rsp_err_d     = 1'b0;
               rsp_timeout_d = 1'b1;
               psel_d        = '0;
               penable_d     = 1'b0;
               rsp_valid_d   = 1'b1;
               state_d       = RESP;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TMO_CW'(1);
            end
`endif
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         state_q     <= IDLE;
         cmd_ready_q <= 1'b0;
         psel_q      <= '0;
         penable_q   <= 1'b0;
         paddr_q     <= '0;
         pwrite_q    <= 1'b0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         paddr_q     <= paddr_d;
         pwrite_q    <= pwrite_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

`ifdef APB_CMD_MASTER_TIMEOUT_EN
   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         tmo_cnt_q     <= '0;
         rsp_timeout_q <= 1'b0;
      end else begin
         tmo_cnt_q     <= tmo_cnt_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end
   assign rsp_timeout = rsp_timeout_q;
`else
   assign rsp_timeout = 1'b0;
`endif

   assign cmd_ready = cmd_ready_q;
   assign PSEL      = psel_q;
   assign PENABLE   = penable_q;
   assign PADDR     = paddr_q;
   assign PWRITE    = pwrite_q;
   assign PWDATA    = pwdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: vector table of single transfers plus corner sequences.
module tb_apb_cmd_master;

   localparam int AW  = 5;
   localparam int DW  = 8;
   localparam int NS  = 2;
   localparam int SW  = 2;
   localparam int TMO = 16;

   logic          PCLK = 1'b0;
   logic          PRESETN;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [SW-1:0] cmd_sel;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
   logic [DW-1:0] rsp_rdata;
   logic [AW-1:0] PADDR;
   logic [NS-1:0] PSEL;
   logic          PENABLE, PWRITE;
   logic [DW-1:0] PWDATA, PRDATA;
   logic          PREADY, PSLVERR;

   int checks   = 0;
   int failures = 0;

   always #5 PCLK = ~PCLK;

   apb_cmd_master #(
      .APB_AW(AW), .APB_DW(DW), .NUM_SLAVES(NS), .SEL_W(SW), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .PCLK(PCLK), .PRESETN(PRESETN),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   typedef struct {
      logic          wr;
      logic [SW-1:0] sel;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] prdata;
      logic          slverr;
      int            waits;
      logic [NS-1:0] exp_psel;
      logic [DW-1:0] exp_pwdata;
      logic [DW-1:0] exp_rdata;
      logic          exp_err;
   } vec_t;

   vec_t vecs[4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge PCLK);
   endtask

   // Full transfer from an idle master; outputs sampled on the falling edge.
   task automatic do_txn(input vec_t v, input string tag);
      chk({tag, "_idle_rdy"}, 32'(cmd_ready), 1);
      cmd_valid = 1'b1; cmd_write = v.wr; cmd_sel = v.sel;
      cmd_addr = v.addr; cmd_wdata = v.wdata;
      tick();
      cmd_valid = 1'b0;
      chk({tag, "_setup_psel"},    32'(PSEL),      32'(v.exp_psel));
      chk({tag, "_setup_penable"}, 32'(PENABLE),   0);
      chk({tag, "_setup_paddr"},   32'(PADDR),     32'(v.addr));
      chk({tag, "_setup_pwrite"},  32'(PWRITE),    32'(v.wr));
      chk({tag, "_setup_pwdata"},  32'(PWDATA),    32'(v.exp_pwdata));
      chk({tag, "_setup_rdy"},     32'(cmd_ready), 0);
      tick();
      chk({tag, "_acc_penable"}, 32'(PENABLE), 1);
      chk({tag, "_acc_psel"},    32'(PSEL),    32'(v.exp_psel));
      for (int w = 0; w < v.waits; w++) begin
         PREADY = 1'b0; PSLVERR = 1'b1; PRDATA = 'hFF;
         tick();
         chk({tag, "_wait_psel"},    32'(PSEL),      32'(v.exp_psel));
         chk({tag, "_wait_penable"}, 32'(PENABLE),   1);
         chk({tag, "_wait_paddr"},   32'(PADDR),     32'(v.addr));
         chk({tag, "_wait_rvalid"},  32'(rsp_valid), 0);
      end
      PREADY = 1'b1; PRDATA = v.prdata; PSLVERR = v.slverr;
      tick();
      PREADY = 1'b0; PSLVERR = 1'b0;
      chk({tag, "_rsp_valid"},   32'(rsp_valid),   1);
      chk({tag, "_rsp_psel"},    32'(PSEL),        0);
      chk({tag, "_rsp_penable"}, 32'(PENABLE),     0);
      chk({tag, "_rsp_rdata"},   32'(rsp_rdata),   32'(v.exp_rdata));
      chk({tag, "_rsp_err"},     32'(rsp_err),     32'(v.exp_err));
      chk({tag, "_rsp_tmo"},     32'(rsp_timeout), 0);
      chk({tag, "_rsp_rdy"},     32'(cmd_ready),   0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk({tag, "_done_valid"}, 32'(rsp_valid), 0);
      chk({tag, "_done_rdy"},   32'(cmd_ready), 1);
   endtask

   initial begin
      //          wr    sel    addr    wdata   prdata  err  w  psel    pwdata  rdata   err
      vecs[0] = '{1'b1, 2'd0, 5'h00, 8'hA5, 8'h5A, 1'b0, 0, 2'b01, 8'hA5, 8'h00, 1'b0};
      vecs[1] = '{1'b0, 2'd1, 5'h04, 8'h77, 8'h3C, 1'b0, 3, 2'b10, 8'h00, 8'h3C, 1'b0};
      vecs[2] = '{1'b1, 2'd1, 5'h1F, 8'h0F, 8'hEE, 1'b1, 1, 2'b10, 8'h0F, 8'h00, 1'b1};
      vecs[3] = '{1'b0, 2'd0, 5'h0A, 8'h00, 8'hC3, 1'b1, 0, 2'b01, 8'h00, 8'hC3, 1'b1};

      PRESETN = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_sel = '0;
      cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
      PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
      repeat (2) tick();
      chk("reset_cmd_ready", 32'(cmd_ready), 0);
      chk("reset_psel",      32'(PSEL),      0);
      chk("reset_penable",   32'(PENABLE),   0);
      chk("reset_paddr",     32'(PADDR),     0);
      chk("reset_pwdata",    32'(PWDATA),    0);
      chk("reset_rsp_valid", 32'(rsp_valid), 0);
      PRESETN = 1'b1;
      tick();
      chk("first_edge_cmd_ready", 32'(cmd_ready), 1);

      for (int i = 0; i < 4; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

      // Slave error with response backpressure; the next command is held meanwhile.
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_sel = 2'd0; cmd_addr = 'h11; cmd_wdata = '0;
      tick();
      cmd_write = 1'b1; cmd_sel = 2'd1; cmd_addr = 'h12; cmd_wdata = 'h99;
      chk("bp_setup_rdy", 32'(cmd_ready), 0);
      tick();
      PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 'h44;
      tick();
      PREADY = 1'b0; PSLVERR = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("bp_hold_valid", 32'(rsp_valid), 1);
         chk("bp_hold_err",   32'(rsp_err),   1);
         chk("bp_hold_rdata", 32'(rsp_rdata), 'h44);
         chk("bp_hold_rdy",   32'(cmd_ready), 0);
         chk("bp_hold_psel",  32'(PSEL),      0);
         tick();
      end
      rsp_ready = 1'b1;
      chk("bp_last_valid", 32'(rsp_valid), 1);
      tick();
      rsp_ready = 1'b0;
      chk("bp_hs_valid", 32'(rsp_valid), 0);
      chk("bp_hs_rdy",   32'(cmd_ready), 1);
      tick();
      cmd_valid = 1'b0;
      chk("bp_next_psel",   32'(PSEL),   'b10);
      chk("bp_next_paddr",  32'(PADDR),  'h12);
      chk("bp_next_pwdata", 32'(PWDATA), 'h99);
      chk("bp_next_pwrite", 32'(PWRITE), 1);
      tick();
      PREADY = 1'b1;
      tick();
      PREADY = 1'b0;
      chk("bp_next_valid", 32'(rsp_valid), 1);
      chk("bp_next_err",   32'(rsp_err),   0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // Out-of-range select answers at once and leaves the bus untouched.
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_sel = 2'd3; cmd_addr = 'h1E; cmd_wdata = 'h55;
      tick();
      cmd_valid = 1'b0;
      chk("badsel_valid",   32'(rsp_valid), 1);
      chk("badsel_err",     32'(rsp_err),   1);
      chk("badsel_rdata",   32'(rsp_rdata), 0);
      chk("badsel_psel",    32'(PSEL),      0);
      chk("badsel_penable", 32'(PENABLE),   0);
      chk("badsel_paddr",   32'(PADDR),     'h12);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("badsel_done_rdy", 32'(cmd_ready), 1);
      do_txn(vecs[0], "errclr");

`ifdef APB_CMD_MASTER_TIMEOUT_EN
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_sel = 2'd1; cmd_addr = 'h08;
      tick();
      cmd_valid = 1'b0;
      tick();
      PRDATA = 'hAB;
      for (int k = 1; k <= TMO; k++) begin
         chk("tmo_acc_penable", 32'(PENABLE), 1);
         PREADY = 1'b0;
         tick();
      end
      chk("tmo_valid",   32'(rsp_valid),   1);
      chk("tmo_flag",    32'(rsp_timeout), 1);
      chk("tmo_err",     32'(rsp_err),     0);
      chk("tmo_rdata",   32'(rsp_rdata),   0);
      chk("tmo_psel",    32'(PSEL),        0);
      chk("tmo_penable", 32'(PENABLE),     0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick();
      for (int k = 1; k <= TMO; k++) begin
         chk("tmo2_acc_penable", 32'(PENABLE), 1);
         PREADY = (k == TMO);
         tick();
      end
      PREADY = 1'b0;
      chk("tmo2_valid", 32'(rsp_valid),   1);
      chk("tmo2_flag",  32'(rsp_timeout), 0);
      chk("tmo2_rdata", 32'(rsp_rdata),   'hAB);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
`endif

      // Reset asserted while the slave is inserting wait states.
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_sel = 2'd1; cmd_addr = 'h07;
      tick();
      cmd_valid = 1'b0;
      PREADY = 1'b0;
      tick();
      tick();
      chk("rstmid_penable_pre", 32'(PENABLE), 1);
      #1 PRESETN = 1'b0;
      #1;
      chk("rstmid_psel",      32'(PSEL),      0);
      chk("rstmid_penable",   32'(PENABLE),   0);
      chk("rstmid_rsp_valid", 32'(rsp_valid), 0);
      chk("rstmid_cmd_ready", 32'(cmd_ready), 0);
      chk("rstmid_paddr",     32'(PADDR),     0);
      repeat (2) tick();
      PRESETN = 1'b1;
      #1;
      chk("rstrel_rdy_before_edge", 32'(cmd_ready), 0);
      tick();
      chk("rstrel_rdy",   32'(cmd_ready), 1);
      chk("rstrel_psel",  32'(PSEL),      0);
      chk("rstrel_valid", 32'(rsp_valid), 0);
      do_txn(vecs[1], "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
